// File: rtl/if_stage_pkg.sv
// Shared widths, reset PC and fetch-state encoding for the instruction fetch stage.
package if_stage_pkg;

  localparam int PC_W   = 64;
  localparam int INST_W = 32;
  // Wide enough for many back-to-back redirects that each leave responses outstanding.
  localparam int DROP_W = 8;

  localparam logic [PC_W-1:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bundle: imem request/response channel, decode handshake and redirect.
interface if_stage_if;
  import if_stage_pkg::*;

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [PC_W-1:0]   imem_req_addr;
  logic              imem_resp_valid;
  logic [INST_W-1:0] imem_resp_data;
  logic              inst_valid;
  logic              id_ready;
  logic [INST_W-1:0] inst;
  logic [PC_W-1:0]   inst_pc;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, id_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, id_ready,
           redirect_valid, redirect_pc
  );

endinterface

// File: rtl/if_fetch_buf.sv
// In-order fetch buffer: slots are allocated at request, filled by response, popped by decode.
module if_fetch_buf import if_stage_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic [PC_W-1:0]   alloc_pc,
  input  logic              fill_valid,
  input  logic [INST_W-1:0] fill_data,
  input  logic              pop,
  input  logic              flush,
  output logic              full,
  output logic [DROP_W-1:0] unfilled_cnt,
  output logic              head_valid,
  output logic [INST_W-1:0] head_data,
  output logic [PC_W-1:0]   head_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  head_q, head_d, alloc_q, alloc_d, fill_q, fill_d;
  logic [CNT_W-1:0]  used_q, used_d, pend_q, pend_d;
  logic [DEPTH-1:0]  filled_q, filled_d;
  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] data_mem [DEPTH];
  logic              alloc_ok, fill_ok, pop_ok;

  assign full         = (used_q == CNT_W'(DEPTH));
  assign head_valid   = filled_q[head_q];
  assign head_data    = head_valid ? data_mem[head_q] : '0;
  assign head_pc      = head_valid ? pc_mem[head_q]   : '0;
  assign unfilled_cnt = DROP_W'(pend_q);

  assign alloc_ok = alloc_valid & ~full & ~flush;
  assign fill_ok  = fill_valid & (pend_q != '0) & ~flush;
  assign pop_ok   = pop & head_valid;

  // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
  always_comb begin
    head_d   = head_q;
    alloc_d  = alloc_q;
    fill_d   = fill_q;
    used_d   = used_q;
    pend_d   = pend_q;
    filled_d = filled_q;
    if (flush) begin
      head_d   = '0;
      alloc_d  = '0;
      fill_d   = '0;
      used_d   = '0;
      pend_d   = '0;
      filled_d = '0;
    end else begin
      if (alloc_ok) alloc_d = alloc_q + 1'b1;
      if (fill_ok) begin
        filled_d[fill_q] = 1'b1;
        fill_d           = fill_q + 1'b1;
      end
      if (pop_ok) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + 1'b1;
      end
      used_d = used_q + CNT_W'(alloc_ok) - CNT_W'(pop_ok);
      pend_d = pend_q + CNT_W'(alloc_ok) - CNT_W'(fill_ok);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q   <= '0;
      alloc_q  <= '0;
      fill_q   <= '0;
      used_q   <= '0;
      pend_q   <= '0;
      filled_q <= '0;
    end else begin
      head_q   <= head_d;
      alloc_q  <= alloc_d;
      fill_q   <= fill_d;
      used_q   <= used_d;
      pend_q   <= pend_d;
      filled_q <= filled_d;
    end
  end

  // NOTE: slot payloads are not reset; they are only visible through filled_q, which is.
  always_ff @(posedge clk) begin
    if (alloc_ok) pc_mem[alloc_q]  <= alloc_pc;
    if (fill_ok)  data_mem[fill_q] <= fill_data;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, imem request issue, response drop accounting on redirect.
module if_stage import if_stage_pkg::*; #(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter int              DEPTH    = 2
) (
  input  logic       clk,
  input  logic       rst,
  if_stage_if.master bus
);

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              req_en_q;

  logic              full, head_valid, req_hs, fill_valid, pop, alloc_valid;
  logic [DROP_W-1:0] unfilled;
  logic [INST_W-1:0] head_data;
  logic [PC_W-1:0]   head_pc;

  assign bus.imem_req_valid = req_en_q & ~full;
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = head_valid;
  assign bus.inst           = head_data;
  assign bus.inst_pc        = head_pc;

  assign req_hs      = bus.imem_req_valid & bus.imem_req_ready;
  assign alloc_valid = req_hs & ~bus.redirect_valid;
  assign fill_valid  = bus.imem_resp_valid & (drop_cnt_q == '0) & ~bus.redirect_valid;
  assign pop         = head_valid & bus.id_ready;

  always_comb begin
    pc_d       = pc_q;
    drop_cnt_d = drop_cnt_q;
    if (bus.redirect_valid) begin
      pc_d = align_pc(bus.redirect_pc);
      // Every response still owed becomes a drop; one arriving now is consumed immediately.
      drop_cnt_d = drop_cnt_q + unfilled + DROP_W'(req_hs) - DROP_W'(bus.imem_resp_valid);
    end else begin
      if (req_hs) pc_d = pc_q + PC_W'(4);
      if (bus.imem_resp_valid && drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (drop_cnt_d != '0) state_d = FLUSH;
      FLUSH:   if (drop_cnt_d == '0) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      drop_cnt_q <= '0;
      req_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_cnt_q <= drop_cnt_d;
      req_en_q   <= 1'b1;
    end
  end

  if_fetch_buf #(.DEPTH(DEPTH)) u_buf (
    .clk          (clk),
    .rst          (rst),
    .alloc_valid  (alloc_valid),
    .alloc_pc     (pc_q),
    .fill_valid   (fill_valid),
    .fill_data    (bus.imem_resp_data),
    .pop          (pop),
    .flush        (bus.redirect_valid),
    .full         (full),
    .unfilled_cnt (unfilled),
    .head_valid   (head_valid),
    .head_data    (head_data),
    .head_pc      (head_pc)
  );

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: in-order memory model, expected-instruction queue, redirect and reset scenarios.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic clk;
  logic rst;
  if_stage_if ifc ();

  if_stage #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
    int          cyc;
  } mem_req_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] data;
  } exp_t;

  mem_req_t    mem_q[$];
  exp_t        exp_q[$];
  logic [63:0] req_log[$];
  int          req_cyc[$];
  logic [63:0] pop_log[$];
  int cyc      = 0;
  int mem_lat  = 1;
  int n_checks = 0;
  int n_fail   = 0;
  int cyc0     = 0;
  bit did_redir;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_C3C3;
  endfunction

  // One clock of stimulus, driven at the falling edge; pops are scored against exp_q.
  task automatic step(input logic rdy, input logic mem_rdy, input logic redir,
                      input logic collide_only, input logic [63:0] rpc);
    mem_req_t m;
    exp_t     e;
    logic     hs, rsp;
    @(negedge clk);
    cyc++;
    ifc.id_ready       = rdy;
    ifc.imem_req_ready = mem_rdy;
    rsp = (mem_q.size() > 0) && (cyc >= mem_q[0].cyc + mem_lat);
    hs  = ifc.imem_req_valid && mem_rdy;
    did_redir = redir && (!collide_only || (hs && rsp));
    ifc.imem_resp_valid = rsp;
    ifc.imem_resp_data  = 32'h0;
    if (rsp) begin
      m = mem_q.pop_front();
      ifc.imem_resp_data = m.data;
    end
    ifc.redirect_valid = did_redir;
    ifc.redirect_pc    = rpc;
    if (ifc.inst_valid && rdy) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got pc=%h inst=%h, required no instruction", ifc.inst_pc, ifc.inst);
      end else begin
        e = exp_q.pop_front();
        if (ifc.inst_pc !== e.pc || ifc.inst !== e.data) begin
          n_fail++;
          $display("FAIL pop_order: got pc=%h inst=%h, required pc=%h inst=%h", ifc.inst_pc, ifc.inst, e.pc, e.data);
        end
      end
      pop_log.push_back(ifc.inst_pc);
    end
    if (hs) begin
      m.addr = ifc.imem_req_addr;
      m.data = mem_word(m.addr);
      m.cyc  = cyc;
      mem_q.push_back(m);
      req_log.push_back(m.addr);
      req_cyc.push_back(cyc);
      if (!did_redir) begin
        e.pc   = m.addr;
        e.data = m.data;
        exp_q.push_back(e);
      end
    end
    if (did_redir) exp_q.delete();
  endtask

  // Stop requesting and let every owed response and buffered instruction come out.
  task automatic drain(input string name);
    for (int i = 0; i < 40; i++) begin
      if (mem_q.size() == 0 && exp_q.size() == 0 && !ifc.inst_valid) break;
      step(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    n_checks++;
    if (exp_q.size() != 0 || ifc.inst_valid || dut.drop_cnt_q != '0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d expected left, inst_valid=%b drop_cnt=%0d, required 0/0/0",
               name, exp_q.size(), ifc.inst_valid, dut.drop_cnt_q);
    end
  endtask

  task automatic clear_logs();
    req_log.delete();
    req_cyc.delete();
    pop_log.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ifc.imem_req_ready  = 1'b0;
    ifc.imem_resp_valid = 1'b0;
    ifc.imem_resp_data  = 32'h0;
    ifc.id_ready        = 1'b0;
    ifc.redirect_valid  = 1'b0;
    ifc.redirect_pc     = 64'h0;
    #23;
    n_checks++;
    if (ifc.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b required 0", ifc.imem_req_valid); end
    n_checks++;
    if (ifc.inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid: got %b required 0", ifc.inst_valid); end
    n_checks++;
    if (ifc.inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h required 0", ifc.inst); end
    n_checks++;
    if (ifc.inst_pc !== 64'h0) begin n_fail++; $display("FAIL reset_inst_pc: got %h required 0", ifc.inst_pc); end
    n_checks++;
    if (ifc.imem_req_addr !== RST_PC) begin n_fail++; $display("FAIL reset_addr: got %h required %h", ifc.imem_req_addr, RST_PC); end
    @(negedge clk);
    rst = 1'b1;
    cyc0 = cyc;
  endtask

  task automatic test_stream();
    clear_logs();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
    n_checks++;
    if (req_log.size() < 3 || req_log[0] !== RST_PC || req_log[1] !== RST_PC + 64'd4 || req_log[2] !== RST_PC + 64'd8) begin
      n_fail++;
      $display("FAIL stream_addrs: got %0d requests starting %h, required %h,+4,+8", req_log.size(),
               (req_log.size() > 0) ? req_log[0] : 64'h0, RST_PC);
    end
    n_checks++;
    if (req_cyc.size() < 2 || req_cyc[0] != cyc0 + 1 || req_cyc[1] != req_cyc[0] + 1) begin
      n_fail++;
      $display("FAIL stream_first_cycles: got first request in cycle %0d, required %0d and %0d back to back",
               (req_cyc.size() > 0) ? req_cyc[0] - cyc0 : -1, 1, 2);
    end
    drain("stream");
    n_checks++;
    if (pop_log.size() != req_log.size()) begin
      n_fail++;
      $display("FAIL stream_count: got %0d instructions, required %0d", pop_log.size(), req_log.size());
    end
  endtask

  task automatic test_stall();
    logic [63:0] pc0;
    logic [31:0] in0;
    clear_logs();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    n_checks++;
    if (exp_q.size() == 0 || ifc.inst_valid !== 1'b1 || ifc.inst_pc !== exp_q[0].pc || ifc.inst !== exp_q[0].data) begin
      n_fail++;
      $display("FAIL stall_head: got valid=%b pc=%h inst=%h, required head of %0d queued",
               ifc.inst_valid, ifc.inst_pc, ifc.inst, exp_q.size());
    end
    pc0 = ifc.inst_pc;
    in0 = ifc.inst;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (ifc.imem_req_valid !== 1'b0 || ifc.inst_pc !== pc0 || ifc.inst !== in0) begin
        n_fail++;
        $display("FAIL stall_hold: got req_valid=%b pc=%h inst=%h, required 0 %h %h",
                 ifc.imem_req_valid, ifc.inst_pc, ifc.inst, pc0, in0);
      end
      step(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    end
    n_checks++;
    if (req_log.size() != 2) begin
      n_fail++;
      $display("FAIL stall_req_count: got %0d requests, required 2", req_log.size());
    end
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
    drain("stall");
    n_checks++;
    if (pop_log.size() != req_log.size()) begin
      n_fail++;
      $display("FAIL stall_count: got %0d instructions, required %0d", pop_log.size(), req_log.size());
    end
  endtask

  task automatic test_redirect();
    int nreq;
    clear_logs();
    mem_lat = 3;
    step(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 64'h0000_0000_8000_1002);
    nreq = req_log.size();
    pop_log.delete();
    @(posedge clk);
    #1;
    n_checks++;
    if (dut.state_q !== FLUSH || dut.drop_cnt_q != DROP_W'(mem_q.size()) || mem_q.size() != 2) begin
      n_fail++;
      $display("FAIL redirect_flush: got state=%0d drop_cnt=%0d, required FLUSH with %0d owed (2)",
               dut.state_q, dut.drop_cnt_q, mem_q.size());
    end
    n_checks++;
    if (ifc.inst_valid !== 1'b0 || ifc.imem_req_addr !== 64'h0000_0000_8000_1000) begin
      n_fail++;
      $display("FAIL redirect_pc: got inst_valid=%b addr=%h, required 0 80001000", ifc.inst_valid, ifc.imem_req_addr);
    end
    mem_lat = 1;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
    drain("redirect");
    n_checks++;
    if (pop_log.size() == 0 || pop_log[0] !== 64'h0000_0000_8000_1000 || pop_log.size() != req_log.size() - nreq) begin
      n_fail++;
      $display("FAIL redirect_stream: got %0d instructions first %h, required %0d first 80001000",
               pop_log.size(), (pop_log.size() > 0) ? pop_log[0] : 64'h0, req_log.size() - nreq);
    end
    n_checks++;
    if (dut.state_q !== FETCH) begin n_fail++; $display("FAIL redirect_state_back: got %0d required FETCH", dut.state_q); end
  endtask

  task automatic test_redirect_collide();
    int nreq;
    clear_logs();
    mem_lat = 1;
    did_redir = 1'b0;
    for (int i = 0; i < 10 && !did_redir; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 64'h0000_0000_8000_2000);
    n_checks++;
    if (!did_redir) begin n_fail++; $display("FAIL collide_setup: got no cycle with request+response, required one within 10"); end
    nreq = req_log.size();
    pop_log.delete();
    @(posedge clk);
    #1;
    n_checks++;
    if (dut.drop_cnt_q != DROP_W'(mem_q.size()) || mem_q.size() == 0) begin
      n_fail++;
      $display("FAIL collide_drop_cnt: got %0d, required %0d (nonzero)", dut.drop_cnt_q, mem_q.size());
    end
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
    drain("collide");
    n_checks++;
    if (pop_log.size() == 0 || pop_log[0] !== 64'h0000_0000_8000_2000 || pop_log.size() != req_log.size() - nreq) begin
      n_fail++;
      $display("FAIL collide_stream: got %0d instructions first %h, required %0d first 80002000",
               pop_log.size(), (pop_log.size() > 0) ? pop_log[0] : 64'h0, req_log.size() - nreq);
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    n_checks++;
    if (ifc.inst_valid !== 1'b1 || ifc.imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_full: got inst_valid=%b req_valid=%b, required 1 0", ifc.inst_valid, ifc.imem_req_valid);
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (ifc.imem_req_valid !== 1'b0 || ifc.inst_valid !== 1'b0 || ifc.inst !== 32'h0 || ifc.inst_pc !== 64'h0 ||
        ifc.imem_req_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL midrst_clear: got req_valid=%b inst_valid=%b inst=%h inst_pc=%h addr=%h, required 0 0 0 0 %h",
               ifc.imem_req_valid, ifc.inst_valid, ifc.inst, ifc.inst_pc, ifc.imem_req_addr, RST_PC);
    end
    mem_q.delete();
    exp_q.delete();
    clear_logs();
    ifc.imem_resp_valid = 1'b0;
    ifc.redirect_valid  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cyc0 = cyc;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
    n_checks++;
    if (req_log.size() == 0 || req_log[0] !== RST_PC || req_cyc[0] != cyc0 + 1) begin
      n_fail++;
      $display("FAIL midrst_restart: got first addr %h, required %h in first cycle", (req_log.size() > 0) ? req_log[0] : 64'h0, RST_PC);
    end
    drain("midrst");
  endtask

  task automatic test_pc_wrap();
    clear_logs();
    step(1'b1, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
    n_checks++;
    if (req_log.size() < 2 || req_log[0] !== 64'hFFFF_FFFF_FFFF_FFFC || req_log[1] !== 64'h0) begin
      n_fail++;
      $display("FAIL wrap_addrs: got %h %h, required fffffffffffffffc 0000000000000000",
               (req_log.size() > 0) ? req_log[0] : 64'h0, (req_log.size() > 1) ? req_log[1] : 64'h0);
    end
    drain("wrap");
    n_checks++;
    if (pop_log.size() < 2 || pop_log[0] !== 64'hFFFF_FFFF_FFFF_FFFC || pop_log[1] !== 64'h0) begin
      n_fail++;
      $display("FAIL wrap_inst_pc: got %0d instructions, required fffffffffffffffc then 0 first", pop_log.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_collide();
    test_reset_mid();
    test_pc_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
